// File: rtl/eq_pkg.sv
// Shared types and defaults for the equalizer gain scheduler.
// Band indices are 1-based on the configuration port; lanes are indexed from 0 internally.
package eq_pkg;

    localparam int DEF_GAIN_WIDTH = 8;
    localparam int DEF_NUM_BANDS  = 10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_COMMIT = 2'd1,
        ST_RAMP   = 2'd2
    } state_e;

    typedef logic [3:0] band_idx_t;

    typedef logic [DEF_NUM_BANDS-1:0][DEF_GAIN_WIDTH-1:0] gain_array_t;

endpackage

// File: rtl/eq_gain_ramp_lane.sv
// One band lane: holds target and live gain and walks live toward the
// effective target by at most RAMP_STEP per enabled step, never overshooting.
module eq_gain_ramp_lane #(
    parameter int GAIN_WIDTH = 8,
    parameter int RAMP_STEP  = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         load,
    input  logic                         step_en,
    input  logic                         mute,
    input  logic signed [GAIN_WIDTH-1:0] staged,
    output logic signed [GAIN_WIDTH-1:0] live,
    output logic                         lane_done,
    output logic                         lane_settled
);

    localparam logic signed [GAIN_WIDTH:0] STEP_POS = (GAIN_WIDTH+1)'(RAMP_STEP);
    localparam logic signed [GAIN_WIDTH:0] STEP_NEG = -STEP_POS;

    logic signed [GAIN_WIDTH-1:0] target_r;
    logic signed [GAIN_WIDTH-1:0] live_r;
    logic signed [GAIN_WIDTH-1:0] eff_s;
    logic signed [GAIN_WIDTH-1:0] live_next_s;
    logic signed [GAIN_WIDTH:0]   diff_s;
    logic signed [GAIN_WIDTH:0]   inc_s;
    logic signed [GAIN_WIDTH:0]   sum_s;

    // Clamped step toward the effective target; the one extra bit keeps the difference from wrapping.
    always_comb begin
        eff_s  = mute ? '0 : target_r;
        diff_s = {eff_s[GAIN_WIDTH-1], eff_s} - {live_r[GAIN_WIDTH-1], live_r};
        if (diff_s > STEP_POS) begin
            inc_s = STEP_POS;
        end else if (diff_s < STEP_NEG) begin
            inc_s = STEP_NEG;
        end else begin
            inc_s = diff_s;
        end
        sum_s = {live_r[GAIN_WIDTH-1], live_r} + inc_s;
        if (step_en) begin
            live_next_s = sum_s[GAIN_WIDTH-1:0];
        end else begin
            live_next_s = live_r;
        end
    end

    // Target and live gain registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            target_r <= '0;
            live_r   <= '0;
        end else begin
            target_r <= load ? staged : target_r;
            live_r   <= live_next_s;
        end
    end

    assign live         = live_r;
    assign lane_done    = (live_r == eff_s);
    assign lane_settled = (live_next_s == eff_s);

endmodule

// File: rtl/eq_gain_scheduler.sv
// Gain scheduler for the ten-band equalizer: staged writes, atomic commit,
// and per-sample bounded ramping of the live gains toward their targets.
module eq_gain_scheduler
    import eq_pkg::*;
#(
    parameter int GAIN_WIDTH = DEF_GAIN_WIDTH,
    parameter int NUM_BANDS  = DEF_NUM_BANDS,
    parameter int RAMP_STEP  = 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            sample_tick,
    input  logic                            cfg_valid,
    output logic                            cfg_ready,
    input  band_idx_t                       cfg_band,
    input  logic [GAIN_WIDTH-1:0]           cfg_gain,
    input  logic                            commit,
    input  logic                            mute,
    output logic [NUM_BANDS*GAIN_WIDTH-1:0] gain_bus,
    output logic                            busy,
    output logic                            cfg_err
);

    localparam band_idx_t MAX_BAND = band_idx_t'(NUM_BANDS);

    logic [NUM_BANDS-1:0][GAIN_WIDTH-1:0] staged_r;
    logic [NUM_BANDS-1:0]                 lane_done_s;
    logic [NUM_BANDS-1:0]                 lane_settled_s;
    state_e state_r;
    state_e state_next_s;
    logic   wr_acc_s;
    logic   band_ok_s;
    logic   cfg_err_r;
    logic   all_done_s;
    logic   all_settled_s;
    logic   load_s;
    logic   step_en_s;

    assign cfg_ready     = (state_r != ST_COMMIT);
    assign wr_acc_s      = cfg_valid & cfg_ready;
    assign band_ok_s     = (cfg_band != 4'd0) && (cfg_band <= MAX_BAND);
    assign load_s        = (state_r == ST_COMMIT);
    assign step_en_s     = sample_tick && (state_r == ST_RAMP);
    assign all_done_s    = &lane_done_s;
    assign all_settled_s = &lane_settled_s;
    assign busy          = load_s || !all_done_s;
    assign cfg_err       = cfg_err_r;

    // Staging bank; invalid band writes are accepted but touch nothing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            staged_r <= '0;
        end else begin
            for (int i = 0; i < NUM_BANDS; i++) begin
                if (wr_acc_s && band_ok_s && (cfg_band == band_idx_t'(i + 1))) begin
                    staged_r[i] <= cfg_gain;
                end else begin
                    staged_r[i] <= staged_r[i];
                end
            end
        end
    end

    // One-cycle error pulse after an accepted write to a nonexistent band.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_err_r <= 1'b0;
        end else begin
            cfg_err_r <= wr_acc_s && !band_ok_s;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next state; leaving RAMP looks at the lanes after this cycle's step.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (commit) begin
                    state_next_s = ST_COMMIT;
                end else if (!all_done_s) begin
                    state_next_s = ST_RAMP;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_COMMIT: begin
                state_next_s = ST_RAMP;
            end
            ST_RAMP: begin
                if (commit) begin
                    state_next_s = ST_COMMIT;
                end else if (all_settled_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_RAMP;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    for (genvar g = 0; g < NUM_BANDS; g++) begin : g_lane
        eq_gain_ramp_lane #(
            .GAIN_WIDTH (GAIN_WIDTH),
            .RAMP_STEP  (RAMP_STEP)
        ) u_lane (
            .clk          (clk),
            .rst_n        (rst_n),
            .load         (load_s),
            .step_en      (step_en_s),
            .mute         (mute),
            .staged       (staged_r[g]),
            .live         (gain_bus[g*GAIN_WIDTH +: GAIN_WIDTH]),
            .lane_done    (lane_done_s[g]),
            .lane_settled (lane_settled_s[g])
        );
    end

endmodule

// File: tb/tb_eq_gain_scheduler.sv
// Directed bench for eq_gain_scheduler: two instances (ramp step 1 and 2) share stimulus
// and are checked every cycle against an arithmetic model plus hand-computed expectations.
module tb_eq_gain_scheduler;

    localparam int NB = 10;
    localparam int GW = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sample_tick = 1'b0;
    logic cfg_valid = 1'b0;
    logic [3:0] cfg_band = 4'd0;
    logic signed [GW-1:0] cfg_gain = '0;
    logic commit = 1'b0;
    logic mute = 1'b0;

    logic ready1, busy1, err1, ready2, busy2, err2;
    logic [NB*GW-1:0] bus1, bus2;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    eq_gain_scheduler #(.GAIN_WIDTH(GW), .NUM_BANDS(NB), .RAMP_STEP(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick), .cfg_valid(cfg_valid),
        .cfg_ready(ready1), .cfg_band(cfg_band), .cfg_gain(cfg_gain), .commit(commit),
        .mute(mute), .gain_bus(bus1), .busy(busy1), .cfg_err(err1));

    eq_gain_scheduler #(.GAIN_WIDTH(GW), .NUM_BANDS(NB), .RAMP_STEP(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick), .cfg_valid(cfg_valid),
        .cfg_ready(ready2), .cfg_band(cfg_band), .cfg_gain(cfg_gain), .commit(commit),
        .mute(mute), .gain_bus(bus2), .busy(busy2), .cfg_err(err2));

    // ---------------- behavioural model (mode 0=idle, 1=commit, 2=ramp) ----------------
    int stg [2][1:NB];
    int tgt [2][1:NB];
    int liv [2][1:NB];
    int mode [2];
    bit err_m [2];
    int step_of [2] = '{1, 2};

    function automatic int eff_of(input int t);
        return mute ? 0 : t;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < 2; s++) begin
                for (int k = 1; k <= NB; k++) begin
                    stg[s][k] = 0; tgt[s][k] = 0; liv[s][k] = 0;
                end
                mode[s] = 0; err_m[s] = 1'b0;
            end
        end else begin
            for (int s = 0; s < 2; s++) begin
                bit acc, any_diff;
                int d;
                acc = cfg_valid && (mode[s] != 1);
                err_m[s] = acc && (cfg_band < 1 || cfg_band > NB);
                if (acc && cfg_band >= 1 && cfg_band <= NB) stg[s][cfg_band] = int'(cfg_gain);
                any_diff = 1'b0;
                for (int k = 1; k <= NB; k++) if (liv[s][k] != eff_of(tgt[s][k])) any_diff = 1'b1;
                if (mode[s] == 1) begin
                    for (int k = 1; k <= NB; k++) tgt[s][k] = stg[s][k];
                    mode[s] = 2;
                end else if (mode[s] == 0) begin
                    if (commit) mode[s] = 1;
                    else if (any_diff) mode[s] = 2;
                end else begin
                    if (sample_tick) begin
                        for (int k = 1; k <= NB; k++) begin
                            d = eff_of(tgt[s][k]) - liv[s][k];
                            if (d > step_of[s]) d = step_of[s];
                            if (d < -step_of[s]) d = -step_of[s];
                            liv[s][k] += d;
                        end
                    end
                    any_diff = 1'b0;
                    for (int k = 1; k <= NB; k++) if (liv[s][k] != eff_of(tgt[s][k])) any_diff = 1'b1;
                    if (commit) mode[s] = 1;
                    else if (!any_diff) mode[s] = 0;
                end
            end
        end
    end

    function automatic logic [NB*GW-1:0] model_bus(input int s);
        logic [NB*GW-1:0] b;
        for (int k = 1; k <= NB; k++) b[k*GW-1 -: GW] = liv[s][k][GW-1:0];
        return b;
    endfunction

    function automatic bit model_busy(input int s);
        bit b;
        b = (mode[s] == 1);
        for (int k = 1; k <= NB; k++) if (liv[s][k] != eff_of(tgt[s][k])) b = 1'b1;
        return b;
    endfunction

    // Per-cycle comparison of both instances against the model, away from the clock edge.
    always @(posedge clk) begin
        #2;
        for (int s = 0; s < 2; s++) begin
            logic [NB*GW-1:0] bus_a;
            logic rdy_a, busy_a, err_a;
            bus_a  = (s == 0) ? bus1 : bus2;
            rdy_a  = (s == 0) ? ready1 : ready2;
            busy_a = (s == 0) ? busy1 : busy2;
            err_a  = (s == 0) ? err1 : err2;
            n_checks += 4;
            if (bus_a !== model_bus(s)) begin
                n_fail++; $display("FAIL model_bus[%0d] t=%0t got %h expected %h", s, $time, bus_a, model_bus(s));
            end
            if (rdy_a !== (mode[s] != 1)) begin
                n_fail++; $display("FAIL model_ready[%0d] t=%0t got %b expected %b", s, $time, rdy_a, mode[s] != 1);
            end
            if (busy_a !== model_busy(s)) begin
                n_fail++; $display("FAIL model_busy[%0d] t=%0t got %b expected %b", s, $time, busy_a, model_busy(s));
            end
            if (err_a !== err_m[s]) begin
                n_fail++; $display("FAIL model_err[%0d] t=%0t got %b expected %b", s, $time, err_a, err_m[s]);
            end
        end
    end

    // ---------------- directed helpers ----------------
    function automatic int band_of(input logic [NB*GW-1:0] bus, input int k);
        logic signed [GW-1:0] v;
        v = bus[k*GW-1 -: GW];
        return int'(v);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic write(input int band, input int gain);
        @(negedge clk);
        cfg_valid = 1'b1; cfg_band = 4'(band); cfg_gain = GW'(gain);
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    task automatic do_commit();
        @(negedge clk); commit = 1'b1;
        @(negedge clk); commit = 1'b0;
    endtask

    task automatic tick();
        @(negedge clk); sample_tick = 1'b1;
        @(negedge clk); sample_tick = 1'b0;
    endtask

    initial begin
        #1;
        check("rst_ready", int'(ready1), 1);
        check("rst_bus", int'(bus1 == '0), 1);
        check("rst_busy", int'(busy1), 0);
        check("rst_err", int'(err1), 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        // band 1 = +3, three ticks
        write(1, 3);
        do_commit();
        check("t1_ready_in_commit", int'(ready1), 0);
        check("t1_busy_in_commit", int'(busy1), 1);
        tick();
        check("t1_g1_tick1", band_of(bus1, 1), 1);
        check("t1_s2_g1_tick1", band_of(bus2, 1), 2);
        tick();
        check("t1_g1_tick2", band_of(bus1, 1), 2);
        check("t1_busy_tick2", int'(busy1), 1);
        tick();
        check("t1_g1_tick3", band_of(bus1, 1), 3);
        check("t1_busy_tick3", int'(busy1), 0);
        check("t1_g2_untouched", band_of(bus1, 2), 0);

        // band 2 = -3: clamp behaviour with step 2
        write(2, -3);
        do_commit();
        tick();
        check("t2_s2_g2_tick1", band_of(bus2, 2), -2);
        check("t2_s1_g2_tick1", band_of(bus1, 2), -1);
        tick();
        check("t2_s2_g2_tick2", band_of(bus2, 2), -3);
        check("t2_s2_busy_tick2", int'(busy2), 0);
        tick();
        check("t2_s1_g2_tick3", band_of(bus1, 2), -3);
        check("t2_s1_busy_tick3", int'(busy1), 0);

        // invalid bands
        write(11, 5);
        check("t3_err_band11", int'(err1), 1);
        @(negedge clk);
        check("t3_err_clear", int'(err1), 0);
        write(0, 7);
        check("t3_err_band0", int'(err1), 1);
        check("t3_g1_kept", band_of(bus1, 1), 3);

        // write and commit in the same cycle
        @(negedge clk);
        cfg_valid = 1'b1; cfg_band = 4'd3; cfg_gain = 8'sd5; commit = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0; commit = 1'b0;
        check("t4_ready_low", int'(ready1), 0);
        @(negedge clk);
        check("t4_ready_back", int'(ready1), 1);
        for (int i = 0; i < 4; i++) tick();
        check("t4_g3_tick4", band_of(bus1, 3), 4);
        tick();
        check("t4_g3_tick5", band_of(bus1, 3), 5);
        check("t4_busy_done", int'(busy1), 0);

        // mute ramp down and back
        write(1, 4);
        do_commit();
        tick();
        check("t5_g1_at4", band_of(bus1, 1), 4);
        @(negedge clk); mute = 1'b1;
        #1;
        check("t5_busy_on_mute", int'(busy1), 1);
        for (int i = 3; i >= 0; i--) begin
            tick();
            check("t5_g1_down", band_of(bus1, 1), i);
        end
        tick();
        check("t5_g3_muted", band_of(bus1, 3), 0);
        check("t5_busy_muted", int'(busy1), 0);
        @(negedge clk); mute = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            check("t5_g1_up", band_of(bus1, 1), i);
        end
        tick();
        check("t5_g3_restored", band_of(bus1, 3), 5);
        check("t5_busy_restored", int'(busy1), 0);

        // reset mid-ramp
        write(4, 6);
        do_commit();
        tick(); tick();
        check("t6_g4_mid", band_of(bus1, 4), 2);
        check("t6_s2_g4_mid", band_of(bus2, 4), 4);
        @(negedge clk); rst_n = 1'b0;
        #1;
        check("t6_bus_cleared", int'(bus1 == '0), 1);
        check("t6_busy_cleared", int'(busy1), 0);
        @(negedge clk); rst_n = 1'b1;
        check("t6_ready_after", int'(ready1), 1);
        tick(); tick(); tick();
        check("t6_no_resume", int'(bus1 == '0), 1);
        check("t6_s2_no_resume", int'(bus2 == '0), 1);
        check("t6_busy_idle", int'(busy1), 0);

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/eq_gain_scheduler.md
# eq_gain_scheduler

Control block that owns the ten band gains feeding the equalizer's weighted-sum datapath. Software or a host FSM writes per-band gains into staging registers through a valid/ready port. A commit pulse transfers all staged values to the targets atomically. The live gains then ramp toward the targets by a bounded step once per audio sample, which avoids zipper noise. Outputs connect directly to the equalizer's gain inputs.

## Interface
- GAIN_WIDTH, 8, width of each signed gain (matches equalizer)
- NUM_BANDS, 10, number of bands
- RAMP_STEP, 1, maximum magnitude change of a live gain per sample_tick (≥1)
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- sample_tick  in  1  one-cycle pulse per audio sample
- cfg_valid  in  1  write request
- cfg_ready  out  1  write accept
- cfg_band  in  4  band index, 1-based (1..NUM_BANDS)
- cfg_gain  in  GAIN_WIDTH  signed staged gain value
- commit  in  1  one-cycle pulse: staged→target for all bands
- mute  in  1  level: effective target of every band is 0 while high
- gain_bus  out  NUM_BANDS*GAIN_WIDTH  live signed gains; band k at [k*GAIN_WIDTH-1:(k-1)*GAIN_WIDTH]
- busy  out  1  some live gain ≠ its effective target, or FSM in COMMIT
- cfg_err  out  1  one-cycle pulse: a write addressed an invalid band

## Operation
- Per-band registers: staged, target, live. All reset to 0.
- Write handshake: a write is accepted on a clk edge when cfg_valid && cfg_ready.
  - Valid band: staged[cfg_band] ← cfg_gain.
  - Band 0 or band >NUM_BANDS: the write is accepted, no register changes, and cfg_err pulses next cycle.
- Effective target: 0 when mute=1, otherwise target.
- FSM states: IDLE, COMMIT, RAMP. Reset state is IDLE.
  - IDLE → COMMIT when commit=1.
  - IDLE → RAMP when any live ≠ effective target (e.g. on a mute edge).
  - COMMIT lasts one cycle: target ← staged for all bands, then go to RAMP.
  - RAMP → COMMIT when commit=1. This retargets the bands; live values continue from where they are.
  - RAMP → IDLE when all live = effective target, evaluated after the step.
- Ramp step, on sample_tick in RAMP: per band, d = eff_target − live, computed in GAIN_WIDTH+1 bits signed.
  - live ← live + clamp(d, −RAMP_STEP, +RAMP_STEP).
  - No overshoot and no wrap.
  - Bands that have already reached their target hold.
- Write and commit in the same cycle: the write lands in staged first, and COMMIT copies the new value.
- commit while in COMMIT: ignored.
- sample_tick during IDLE or COMMIT: ignored.
- Mute change in any state: takes effect at the next step. A mute level never alters target.

## Timing
- Reset values: cfg_ready=1, gain_bus=0, busy=0, cfg_err=0, state IDLE.
- cfg_ready=0 only during the COMMIT cycle. It is combinational from state.
- Staged update is visible one cycle after acceptance. cfg_err asserts in the cycle after acceptance and lasts one cycle.
- Commit sequence:
  - commit sampled at edge N.
  - COMMIT during cycle N..N+1. busy=1 from edge N.
  - RAMP from edge N+1.
  - The first step occurs on the first sample_tick sampled at or after edge N+2.
- gain_bus is registered. It changes at the edge that samples sample_tick.
- busy falls at the same edge as the final step.
- Worst-case settle: ceil(|Δ|/RAMP_STEP) sample_ticks.
- Reset asserted mid-ramp: all registers clear immediately and gain_bus=0 asynchronously.

## Structure
- Package eq_pkg contains:
  - GAIN_WIDTH and NUM_BANDS defaults.
  - The state enum (IDLE/COMMIT/RAMP).
  - The band index type.
  - Packed gain-array typedef.
- Sub-module eq_gain_ramp_lane, instantiated NUM_BANDS times via generate:
  - Holds the target and live registers.
  - Contains the clamp/step logic.
  - Outputs lane_done.
- The top level keeps the staging bank, handshake, FSM and the AND-reduction of lane_done.

## Test plan
- Write band 1=+3, commit, then 3 sample_ticks → gain_1 steps 1, 2, 3; busy falls at the third tick; other bands stay 0.
- RAMP_STEP=2: band 2 target −3 from 0 → live −2 then −3 (clamped, no overshoot); busy=0 after 2 ticks.
- Write to band 11, then band 0 → two cfg_err pulses; staged, target and gain_bus unchanged.
- Write band 3=+5 in the same cycle as commit → COMMIT copies +5; cfg_ready=0 for exactly one cycle; gain_3 reaches 5 after 5 ticks.
- Band 1 at +4, assert mute → steps 3, 2, 1, 0; deassert → ramps back to 4 with no new commit.
- Assert rst_n=0 mid-ramp (gain_4 at 2 of target 6) → all outputs 0 immediately; cfg_ready=1 after release; no ramp resumes.
